// File: rtl/dram_lsu.sv
// Load/store initiator for the single-port-pair data DRAM.
//
// Converts byte-addressed byte/half/word requests from the memory stage into
// word-indexed DRAM reads and writes. Handles lane selection, sign/zero
// extension of loads and read-modify-write for sub-word stores. Misaligned,
// illegal-size and out-of-range requests complete with an error response and
// never touch memory.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   req_valid/ready   request handshake; taken when both high at posedge
//   req_we            1 = store, 0 = load
//   req_size          0 byte, 1 half, 2 word, 3 illegal
//   req_unsigned      zero-extend sub-word loads
//   req_addr          byte address
//   req_wdata         store data, right-aligned
//   resp_valid        one-cycle completion pulse
//   resp_rdata        load result (0 for stores and errors), held between responses
//   resp_err          error flag, valid with resp_valid
//   mem_rd_*          DRAM read port; data returns the cycle after mem_rd_en
//   mem_wr_*          DRAM write port; DRAM commits on the negedge of the strobe cycle
module dram_lsu #(
  parameter int unsigned DATA_W = 32,  // lane logic assumes 32
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_data
);

  typedef enum logic [1:0] {
    StIdle,
    StRd,
    StLd,
    StWr
  } state_e;

  state_e state_q, state_d;

  // Latched request
  logic              we_q;
  logic              uns_q;
  logic [1:0]        size_q;
  logic [1:0]        lane_q;
  logic [ADDR_W-1:0] idx_q;
  logic [31:0]       wdata_q;

  // Registered response
  logic        resp_valid_q, resp_valid_d;
  logic        resp_err_q, resp_err_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;

  logic        accept;
  logic        req_err;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;
  logic [31:0] merged;

  assign req_ready = (state_q == StIdle) & ~rst;
  assign accept    = req_valid & req_ready;

  // Request legality: size, natural alignment and range of the byte space.
  always_comb begin
    req_err = 1'b0;
    case (req_size)
      2'd0:    req_err = 1'b0;
      2'd1:    req_err = req_addr[0];
      2'd2:    req_err = |req_addr[1:0];
      default: req_err = 1'b1;
    endcase
    if (|req_addr[31:ADDR_W+2]) begin
      req_err = 1'b1;
    end
  end

  // Load formatting from the word returned by the DRAM.
  always_comb begin
    ld_byte = mem_rd_data[7:0];
    case (lane_q)
      2'd0:    ld_byte = mem_rd_data[7:0];
      2'd1:    ld_byte = mem_rd_data[15:8];
      2'd2:    ld_byte = mem_rd_data[23:16];
      default: ld_byte = mem_rd_data[31:24];
    endcase
    ld_half = lane_q[1] ? mem_rd_data[31:16] : mem_rd_data[15:0];
    case (size_q)
      2'd0:    ld_data = {{24{~uns_q & ld_byte[7]}}, ld_byte};
      2'd1:    ld_data = {{16{~uns_q & ld_half[15]}}, ld_half};
      default: ld_data = mem_rd_data;
    endcase
  end

  // Sub-word store merge: old word with the addressed lane(s) replaced.
  always_comb begin
    merged = mem_rd_data;
    if (size_q == 2'd0) begin
      case (lane_q)
        2'd0:    merged[7:0]   = wdata_q[7:0];
        2'd1:    merged[15:8]  = wdata_q[7:0];
        2'd2:    merged[23:16] = wdata_q[7:0];
        default: merged[31:24] = wdata_q[7:0];
      endcase
    end else if (lane_q[1]) begin
      merged[31:16] = wdata_q[15:0];
    end else begin
      merged[15:0] = wdata_q[15:0];
    end
  end

  // Next state and response
  always_comb begin
    state_d      = state_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = resp_rdata_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          if (req_err) begin
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
          end else if (req_we && (req_size == 2'd2)) begin
            state_d = StWr;
          end else begin
            // Loads and sub-word stores both start with a read.
            state_d = StRd;
          end
        end
      end
      StRd: begin
        state_d = we_q ? StWr : StLd;
      end
      StLd: begin
        state_d      = StIdle;
        resp_valid_d = 1'b1;
        resp_rdata_d = ld_data;
      end
      StWr: begin
        state_d      = StIdle;
        resp_valid_d = 1'b1;
        resp_rdata_d = '0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= 2'd0;
      lane_q  <= 2'd0;
      idx_q   <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      we_q    <= req_we;
      uns_q   <= req_unsigned;
      size_q  <= req_size;
      lane_q  <= req_addr[1:0];
      idx_q   <= req_addr[ADDR_W+1:2];
      wdata_q <= req_wdata;
    end
  end

  // Strobes come straight from state so the DRAM sees them in the same cycle;
  // reset gates them so a write in flight is suppressed immediately.
  assign mem_rd_en   = (state_q == StRd) & ~rst;
  assign mem_wr_en   = (state_q == StWr) & ~rst;
  assign mem_rd_addr = idx_q;
  assign mem_wr_addr = idx_q;
  assign mem_wr_data = (mem_wr_en && (size_q != 2'd2)) ? merged : wdata_q;

  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_dram_lsu.sv
module tb_dram_lsu;
  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DEPTH  = 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [31:0] mem_rd_data = '0;
  logic        mem_wr_en;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [31:0] mem_wr_data;

  int n_checks = 0;
  int n_fail   = 0;

  // DRAM seen by the DUT, and the byte-level reference model
  logic [31:0] dram [DEPTH];
  logic [7:0]  ref_bytes [DEPTH*4];

  // Observations of the last issued request
  int          obs_lat, obs_nrd, obs_nwr, obs_rd_cyc, obs_wr_cyc;
  logic [31:0] obs_rdata, obs_wdata;
  logic        obs_err;
  logic [11:0] obs_raddr, obs_waddr;

  dram_lsu #(.DATA_W(32), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_rd_en    (mem_rd_en),
    .mem_rd_addr  (mem_rd_addr),
    .mem_rd_data  (mem_rd_data),
    .mem_wr_en    (mem_wr_en),
    .mem_wr_addr  (mem_wr_addr),
    .mem_wr_data  (mem_wr_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_rd_en) mem_rd_data <= dram[mem_rd_addr];
  always @(negedge clk) if (mem_wr_en) dram[mem_wr_addr] <= mem_wr_data;

  // ---------------- reference model ----------------
  function automatic logic model_err(input logic [1:0] size, input logic [31:0] addr);
    int unsigned n;
    if (size == 2'd3) return 1'b1;
    if (addr >= 32'h4000) return 1'b1;
    n = 1 << size;
    return (addr % n) != 0;
  endfunction

  function automatic logic [31:0] model_word(input int unsigned idx);
    return {ref_bytes[idx*4+3], ref_bytes[idx*4+2], ref_bytes[idx*4+1], ref_bytes[idx*4]};
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] size, input logic uns,
                                             input logic [31:0] addr);
    int unsigned n;
    logic [31:0] v;
    n = 1 << size;
    v = '0;
    for (int i = 0; i < int'(n); i++) v = v | (32'(ref_bytes[addr+i]) << (8*i));
    if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
    return v;
  endfunction

  task automatic model_store(input logic [1:0] size, input logic [31:0] addr,
                             input logic [31:0] wd);
    int unsigned n;
    n = 1 << size;
    for (int i = 0; i < int'(n); i++) ref_bytes[addr+i] = wd[8*i +: 8];
  endtask

  // Drive one request and observe it until its response (bounded).
  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    obs_lat = -1; obs_nrd = 0; obs_nwr = 0; obs_rd_cyc = -1; obs_wr_cyc = -1;
    obs_rdata = 'x; obs_err = 1'bx; obs_raddr = '0; obs_waddr = '0; obs_wdata = '0;
    @(posedge clk); #1;
    // Garbage on the request bus while busy must be ignored.
    req_valid = 1'b0; req_we = 1'($urandom); req_size = 2'($urandom);
    req_unsigned = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    for (int c = 1; c <= 8; c++) begin
      if (mem_rd_en) begin obs_nrd++; obs_rd_cyc = c; obs_raddr = mem_rd_addr; end
      if (mem_wr_en) begin
        obs_nwr++; obs_wr_cyc = c; obs_waddr = mem_wr_addr; obs_wdata = mem_wr_data;
      end
      if (resp_valid) begin
        obs_lat = c; obs_rdata = resp_rdata; obs_err = resp_err;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (req_ready !== 1'b0 || resp_valid !== 1'b0 || mem_rd_en !== 1'b0 || mem_wr_en !== 1'b0)
    begin
      n_fail++;
      $display("FAIL reset_outputs: ready=%b valid=%b rd_en=%b wr_en=%b, required all 0",
               req_ready, resp_valid, mem_rd_en, mem_wr_en);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (req_ready !== 1'b1 || resp_rdata !== 32'h0 || resp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: ready=%b rdata=%h err=%b, required 1/0/0",
               req_ready, resp_rdata, resp_err);
    end
  endtask

  task automatic test_word();
    issue(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
    model_store(2'd2, 32'h10, 32'hDEADBEEF);
    n_checks++;
    if (obs_lat !== 2 || obs_wr_cyc !== 1 || obs_waddr !== 12'd4 || obs_wdata !== 32'hDEADBEEF
        || obs_nrd !== 0 || obs_err !== 1'b0 || obs_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL sw_0x10: lat=%0d wrcyc=%0d waddr=%0d wdata=%h nrd=%0d err=%b, required 2/1/4/deadbeef/0/0",
               obs_lat, obs_wr_cyc, obs_waddr, obs_wdata, obs_nrd, obs_err);
    end
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    n_checks++;
    if (obs_lat !== 3 || obs_rd_cyc !== 1 || obs_raddr !== 12'd4 || obs_nwr !== 0
        || obs_rdata !== 32'hDEADBEEF || obs_err !== 1'b0) begin
      n_fail++;
      $display("FAIL lw_0x10: lat=%0d rdcyc=%0d raddr=%0d nwr=%0d rdata=%h err=%b, required 3/1/4/0/deadbeef/0",
               obs_lat, obs_rd_cyc, obs_raddr, obs_nwr, obs_rdata, obs_err);
    end
  endtask

  task automatic test_sub_byte();
    logic [31:0] addrs [3] = '{32'h11, 32'h13, 32'h13};
    logic        unss  [3] = '{1'b0, 1'b0, 1'b1};
    logic [31:0] exps  [3] = '{32'h0000005A, 32'hFFFFFFDE, 32'h000000DE};
    issue(1'b1, 2'd0, 1'b0, 32'h11, 32'hFFFFFF5A);
    model_store(2'd0, 32'h11, 32'hFFFFFF5A);
    n_checks++;
    if (obs_lat !== 3 || obs_rd_cyc !== 1 || obs_wr_cyc !== 2 || obs_waddr !== 12'd4
        || obs_wdata !== 32'hDEAD5AEF || obs_err !== 1'b0) begin
      n_fail++;
      $display("FAIL sb_0x11: lat=%0d rdcyc=%0d wrcyc=%0d waddr=%0d wdata=%h, required 3/1/2/4/dead5aef",
               obs_lat, obs_rd_cyc, obs_wr_cyc, obs_waddr, obs_wdata);
    end
    for (int i = 0; i < 3; i++) begin
      issue(1'b0, 2'd0, unss[i], addrs[i], 32'h0);
      n_checks++;
      if (obs_lat !== 3 || obs_rdata !== exps[i] || obs_err !== 1'b0) begin
        n_fail++;
        $display("FAIL lb_%0d @%h: lat=%0d rdata=%h, required 3/%h",
                 i, addrs[i], obs_lat, obs_rdata, exps[i]);
      end
    end
  endtask

  task automatic test_sub_half();
    logic [31:0] addrs [3] = '{32'h12, 32'h12, 32'h10};
    logic        unss  [3] = '{1'b0, 1'b1, 1'b0};
    logic [31:0] exps  [3] = '{32'hFFFF8001, 32'h00008001, 32'h00005AEF};
    issue(1'b1, 2'd1, 1'b0, 32'h12, 32'h00008001);
    model_store(2'd1, 32'h12, 32'h00008001);
    n_checks++;
    if (obs_lat !== 3 || obs_wdata !== 32'h80015AEF || obs_nrd !== 1 || obs_nwr !== 1) begin
      n_fail++;
      $display("FAIL sh_0x12: lat=%0d wdata=%h nrd=%0d nwr=%0d, required 3/80015aef/1/1",
               obs_lat, obs_wdata, obs_nrd, obs_nwr);
    end
    for (int i = 0; i < 3; i++) begin
      issue(1'b0, 2'd1, unss[i], addrs[i], 32'h0);
      n_checks++;
      if (obs_lat !== 3 || obs_rdata !== exps[i] || obs_err !== 1'b0) begin
        n_fail++;
        $display("FAIL lh_%0d @%h: lat=%0d rdata=%h, required 3/%h",
                 i, addrs[i], obs_lat, obs_rdata, exps[i]);
      end
    end
  endtask

  task automatic test_errors();
    logic        wes   [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [1:0]  sizes [5] = '{2'd2, 2'd1, 2'd2, 2'd3, 2'd2};
    logic [31:0] addrs [5] = '{32'h02, 32'h13, 32'h4000, 32'h20, 32'h4004};
    for (int i = 0; i < 5; i++) begin
      issue(wes[i], sizes[i], 1'b0, addrs[i], 32'hCAFEF00D);
      n_checks++;
      if (obs_lat !== 1 || obs_err !== 1'b1 || obs_rdata !== 32'h0 || obs_nrd !== 0
          || obs_nwr !== 0) begin
        n_fail++;
        $display("FAIL err_%0d: lat=%0d err=%b rdata=%h nrd=%0d nwr=%0d, required 1/1/0/0/0",
                 i, obs_lat, obs_err, obs_rdata, obs_nrd, obs_nwr);
      end
    end
  endtask

  task automatic test_reset_rd();
    logic [31:0] saved;
    bit          bad;
    saved = model_word(8);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_addr = 32'h20;
    req_wdata = ~saved;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n_checks++;
    if (mem_rd_en !== 1'b1) begin
      n_fail++;
      $display("FAIL rstrd_read: rd_en=%b, required 1", mem_rd_en);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (mem_rd_en !== 1'b0 || req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rstrd_gate: rd_en=%b ready=%b, required 0/0", mem_rd_en, req_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rstrd_ready: ready=%b, required 1", req_ready);
    end
    bad = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (mem_wr_en || resp_valid) bad = 1'b1;
      @(posedge clk); #1;
    end
    n_checks++;
    if (bad || dram[8] !== saved) begin
      n_fail++;
      $display("FAIL rstrd_drop: activity=%b word8=%h, required 0/%h", bad, dram[8], saved);
    end
  endtask

  task automatic test_reset_wr();
    logic [31:0] saved;
    bit          bad;
    saved = model_word(9);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 32'h24;
    req_wdata = ~saved;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    n_checks++;
    if (mem_wr_en !== 1'b0) begin
      n_fail++;
      $display("FAIL rstwr_gate: wr_en=%b, required 0", mem_wr_en);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    bad = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (mem_wr_en || resp_valid) bad = 1'b1;
      @(posedge clk); #1;
    end
    n_checks++;
    if (bad || dram[9] !== saved) begin
      n_fail++;
      $display("FAIL rstwr_drop: activity=%b word9=%h, required 0/%h", bad, dram[9], saved);
    end
  endtask

  task automatic test_back_to_back();
    logic        rdy [8];
    logic        vld [8];
    logic [31:0] rd  [8];
    logic [31:0] exp1, exp2;
    exp1 = model_load(2'd2, 1'b0, 32'h10);
    exp2 = model_load(2'd2, 1'b0, 32'h30);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 32'h10; req_wdata = '0;
    @(posedge clk); #1;
    req_addr = 32'h30;
    for (int c = 1; c <= 7; c++) begin
      if (c == 4) req_valid = 1'b0;
      rdy[c] = req_ready; vld[c] = resp_valid; rd[c] = resp_rdata;
      @(posedge clk); #1;
    end
    n_checks++;
    if (rdy[1] !== 1'b0 || rdy[2] !== 1'b0 || rdy[3] !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_ready: T+1..3=%b%b%b, required 001", rdy[1], rdy[2], rdy[3]);
    end
    n_checks++;
    if (vld[3] !== 1'b1 || rd[3] !== exp1) begin
      n_fail++;
      $display("FAIL b2b_resp1: valid=%b rdata=%h, required 1/%h", vld[3], rd[3], exp1);
    end
    n_checks++;
    if (vld[4] !== 1'b0 || vld[5] !== 1'b0 || vld[6] !== 1'b1 || rd[6] !== exp2) begin
      n_fail++;
      $display("FAIL b2b_resp2: valid T+4..6=%b%b%b rdata=%h, required 001/%h",
               vld[4], vld[5], vld[6], rd[6], exp2);
    end
  endtask

  task automatic test_random();
    logic        we, uns, e;
    logic [1:0]  size;
    logic [31:0] addr, wd, exp_rd, exp_wd;
    int          exp_lat, exp_nrd, exp_nwr, r;
    for (int k = 0; k < 80; k++) begin
      we = 1'($urandom); uns = 1'($urandom); wd = $urandom;
      r = int'($urandom_range(0, 9));
      size = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      if ($urandom_range(0, 15) == 0) addr = $urandom_range(32'h4000, 32'hFFFFFFFF);
      else begin
        addr = 32'h100 + $urandom_range(0, 63);
        if ($urandom_range(0, 3) != 0 && size != 2'd3) addr = addr & ~((32'd1 << size) - 1);
      end
      e = model_err(size, addr);
      exp_rd = 32'h0; exp_wd = 32'h0; exp_nrd = 0; exp_nwr = 0;
      if (e) exp_lat = 1;
      else if (!we) begin
        exp_lat = 3; exp_nrd = 1; exp_rd = model_load(size, uns, addr);
      end else begin
        model_store(size, addr, wd);
        exp_wd  = model_word(addr >> 2);
        exp_nwr = 1;
        exp_nrd = (size == 2'd2) ? 0 : 1;
        exp_lat = (size == 2'd2) ? 2 : 3;
      end
      n_checks++;
      if (req_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL rnd%0d_ready: ready=%b, required 1", k, req_ready);
      end
      issue(we, size, uns, addr, wd);
      n_checks++;
      if (obs_lat !== exp_lat || obs_err !== e || obs_rdata !== exp_rd) begin
        n_fail++;
        $display("FAIL rnd%0d_resp we=%b sz=%0d a=%h: lat=%0d err=%b rdata=%h, required %0d/%b/%h",
                 k, we, size, addr, obs_lat, obs_err, obs_rdata, exp_lat, e, exp_rd);
      end
      n_checks++;
      if (obs_nrd !== exp_nrd || obs_nwr !== exp_nwr
          || (exp_nrd == 1 && obs_raddr !== addr[13:2])
          || (exp_nwr == 1 && (obs_waddr !== addr[13:2] || obs_wdata !== exp_wd))) begin
        n_fail++;
        $display("FAIL rnd%0d_mem a=%h: nrd=%0d nwr=%0d raddr=%h waddr=%h wdata=%h, required %0d/%0d/%h/%h/%h",
                 k, addr, obs_nrd, obs_nwr, obs_raddr, obs_waddr, obs_wdata,
                 exp_nrd, exp_nwr, addr[13:2], addr[13:2], exp_wd);
      end
    end
  endtask

  task automatic test_final_mem();
    int bad;
    int first;
    bad = 0; first = -1;
    repeat (2) @(posedge clk);
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (dram[i] !== model_word(i)) begin
        bad++;
        if (first < 0) first = i;
      end
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL final_mem: %0d words differ (first at index %0d), required 0", bad, first);
    end
  endtask

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      dram[i] = $urandom;
      for (int b = 0; b < 4; b++) ref_bytes[i*4+b] = dram[i][8*b +: 8];
    end
    test_reset();
    test_word();
    test_sub_byte();
    test_sub_half();
    test_errors();
    test_reset_rd();
    test_reset_wr();
    test_back_to_back();
    test_random();
    test_final_mem();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
